// File: rtl/qenc_pkg.sv
// Shared constants and transition classifier for the quadrature encoder decoder.
// Forward Gray order is 00 -> 10 -> 11 -> 01 -> 00, written as {A,B}.
package qenc_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    CLS_NONE    = 2'd0,
    CLS_FWD     = 2'd1,
    CLS_REV     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } qenc_cls_e;

  function automatic logic [1:0] qenc_fwd_next(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  // A reverse move is a forward move seen from the other end.
  function automatic qenc_cls_e qenc_classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                     return CLS_NONE;
    else if (cur == qenc_fwd_next(prev)) return CLS_FWD;
    else if (prev == qenc_fwd_next(cur)) return CLS_REV;
    else                                 return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/quad_encoder_ch.sv
// One quadrature channel: A/B synchroniser, optional glitch filter, x4 decoder,
// wrapping position counter and sticky error. Filter enabled by QENC_GLITCH_FILTER_EN.
module quad_encoder_ch
  import qenc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clr_i,
  output logic             step_o,
  output logic             dir_o,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  if (CNT_W < 2 || SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_param_check
    $error("quad_encoder_ch: CNT_W, SYNC_STAGES and FILT_LEN must all be >= 2");
  end

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             s_sync, s_dec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_i};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_i};
    end
  end

  assign s_sync = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QENC_GLITCH_FILTER_EN
  localparam int             FW        = $clog2(FILT_LEN);
  localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 2);

  logic [1:0]    cand_q, filt_q;
  logic [FW-1:0] stab_q;

  // Loading the candidate is the first equal sample, so forward after FILT_LEN-1 more.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_q <= '0;
      filt_q <= '0;
      stab_q <= '0;
    end else if (s_sync != cand_q) begin
      cand_q <= s_sync;
      stab_q <= '0;
    end else if (stab_q == FILT_LAST) begin
      filt_q <= cand_q;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign s_dec = filt_q;
`else
  assign s_dec = s_sync;
`endif

  logic [1:0]       prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             err_q, err_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    err_d    = err_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    if (clr_i) begin
      cnt_d    = '0;
      err_d    = 1'b0;
      primed_d = 1'b0;
    end else if (!primed_q) begin
      prev_d   = s_dec;
      primed_d = 1'b1;
    end else begin
      // prev keeps tracking the input even while the error is latched.
      prev_d = s_dec;
      if (!err_q) begin
        case (qenc_classify(prev_q, s_dec))
          CLS_FWD: begin
            step_d = 1'b1;
            dir_d  = DIR_FWD;
            cnt_d  = cnt_q + 1'b1;
          end
          CLS_REV: begin
            step_d = 1'b1;
            dir_d  = DIR_REV;
            cnt_d  = cnt_q - 1'b1;
          end
          CLS_ILLEGAL: err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      err_q    <= err_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
    end
  end

  assign step_o  = step_q;
  assign dir_o   = dir_q;
  assign count_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/quad_encoder_multi.sv
// NCH independent quadrature encoder channels with packed position counters.
// Optional per-channel glitch filter enabled by QENC_GLITCH_FILTER_EN.
module quad_encoder_multi
  import qenc_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       a_i,
  input  logic [NCH-1:0]       b_i,
  input  logic [NCH-1:0]       clr_i,
  output logic [NCH-1:0]       step_o,
  output logic [NCH-1:0]       dir_o,
  output logic [NCH*CNT_W-1:0] count_o,
  output logic [NCH-1:0]       err_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    quad_encoder_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .a_i     (a_i[i]),
      .b_i     (b_i[i]),
      .clr_i   (clr_i[i]),
      .step_o  (step_o[i]),
      .dir_o   (dir_o[i]),
      .count_o (count_o[i*CNT_W +: CNT_W]),
      .err_o   (err_o[i])
    );
  end

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Directed bench for quad_encoder_multi with a phase-index reference model
// compared every cycle, plus hand-computed literal checks.
module tb_quad_encoder_multi;

  localparam int NCH      = 2;
  localparam int CNT_W    = 16;
  localparam int SYNC     = 2;
  localparam int FILT_LEN = 4;
`ifdef QENC_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT_LEN;
`else
  localparam int LAT = SYNC;
`endif
  localparam int HOLD = LAT + 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       a, b, clr;
  logic [NCH-1:0]       step, dir, err;
  logic [NCH*CNT_W-1:0] count;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses0 = 0;

  logic [1:0] PH [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .clr_i(clr),
    .step_o(step), .dir_o(dir), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int c);
    return count[c*CNT_W +: CNT_W];
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d at %0t: got %0h, expected %0h", name, c, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]       hist   [NCH][SYNC];
  logic [1:0]       shist  [NCH][FILT_LEN-1];
  logic [1:0]       fwd    [NCH];
  logic [1:0]       m_prev [NCH];
  logic             m_primed [NCH];
  logic             m_err  [NCH];
  logic             m_step [NCH];
  logic             m_dir  [NCH];
  logic [CNT_W-1:0] m_pos  [NCH];

  function automatic int ph_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < SYNC; j++) hist[c][j] = 2'b00;
      for (int j = 0; j < FILT_LEN-1; j++) shist[c][j] = 2'b00;
      fwd[c] = 2'b00;
      m_prev[c] = 2'b00;
      m_primed[c] = 1'b0;
      m_err[c] = 1'b0;
      m_step[c] = 1'b0;
      m_dir[c] = 1'b0;
      m_pos[c] = '0;
    end
  endtask

  task automatic m_edge();
    logic [1:0] s, cur;
    int d;
    for (int c = 0; c < NCH; c++) begin
      // input sampled SYNC edges ago reaches the decoder now
      s = hist[c][SYNC-1];
      for (int j = SYNC-1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = {a[c], b[c]};
`ifdef QENC_GLITCH_FILTER_EN
      cur = fwd[c];
      begin
        bit same;
        same = 1'b1;
        for (int j = 0; j < FILT_LEN-1; j++) if (shist[c][j] != s) same = 1'b0;
        if (same) fwd[c] = s;
        for (int j = FILT_LEN-2; j > 0; j--) shist[c][j] = shist[c][j-1];
        shist[c][0] = s;
      end
`else
      cur = s;
`endif
      m_step[c] = 1'b0;
      if (clr[c]) begin
        m_pos[c] = '0;
        m_err[c] = 1'b0;
        m_primed[c] = 1'b0;
      end else if (!m_primed[c]) begin
        m_primed[c] = 1'b1;
        m_prev[c] = cur;
      end else begin
        d = (ph_idx(cur) - ph_idx(m_prev[c]) + 4) % 4;
        if (!m_err[c]) begin
          if (d == 1) begin m_pos[c] = m_pos[c] + 1'b1; m_dir[c] = 1'b1; m_step[c] = 1'b1; end
          else if (d == 3) begin m_pos[c] = m_pos[c] - 1'b1; m_dir[c] = 1'b0; m_step[c] = 1'b1; end
          else if (d == 2) m_err[c] = 1'b1;
        end
        m_prev[c] = cur;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_edge();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        check("m_step",  c, 32'(step[c]),  32'(m_step[c]));
        check("m_dir",   c, 32'(dir[c]),   32'(m_dir[c]));
        check("m_err",   c, 32'(err[c]),   32'(m_err[c]));
        check("m_count", c, 32'(cnt_of(c)), 32'(m_pos[c]));
      end
      if (step[0]) pulses0++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int c, input int idx);
    logic [1:0] ab;
    ab = PH[idx % 4];
    a[c] = ab[1];
    b[c] = ab[0];
  endtask

  task automatic clr_pulse(input logic [NCH-1:0] m);
    clr = m;
    cyc(1);
    clr = '0;
    cyc(4);
  endtask

  int i0, i1;

  initial begin
    rst = 1'b1; a = '0; b = '0; clr = '0;
    cyc(3);
    check("rst_count", 0, 32'(cnt_of(0)), 32'h0);
    check("rst_count", 1, 32'(cnt_of(1)), 32'h0);
    check("rst_flags", 0, 32'({step, dir, err}), 32'h0);
    rst = 1'b0;
    cyc(8);

    // four forward steps on channel 0, latency checked on each
    pulses0 = 0;
    i0 = 0;
    for (int k = 0; k < 4; k++) begin
      i0 = (i0 + 1) % 4;
      drive(0, i0);
      cyc(LAT);
      check("step_early", 0, 32'(step[0]), 32'h0);
      cyc(1);
      check("step_lat", 0, 32'(step[0]), 32'h1);
      cyc(HOLD - LAT - 1);
    end
    check("fwd4_count", 0, 32'(cnt_of(0)), 32'd4);
    check("fwd4_dir", 0, 32'(dir[0]), 32'h1);
    check("fwd4_pulses", 0, pulses0, 32'd4);

    // wrap below zero and back
    clr_pulse(2'b01);
    check("clr_count", 0, 32'(cnt_of(0)), 32'h0);
    i0 = 3; drive(0, i0); cyc(HOLD);
    check("wrap_count", 0, 32'(cnt_of(0)), 32'hFFFF);
    check("wrap_dir", 0, 32'(dir[0]), 32'h0);
    i0 = 0; drive(0, i0); cyc(HOLD);
    check("unwrap_count", 0, 32'(cnt_of(0)), 32'h0);
    check("unwrap_dir", 0, 32'(dir[0]), 32'h1);

    // illegal jump, frozen counter, recovery through CLR
    pulses0 = 0;
    i0 = 2; drive(0, i0); cyc(HOLD);
    check("ill_err", 0, 32'(err[0]), 32'h1);
    check("ill_count", 0, 32'(cnt_of(0)), 32'h0);
    check("ill_nostep", 0, pulses0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      i0 = (i0 + 1) % 4; drive(0, i0); cyc(HOLD);
    end
    check("frozen_count", 0, 32'(cnt_of(0)), 32'h0);
    check("frozen_err", 0, 32'(err[0]), 32'h1);
    clr_pulse(2'b01);
    check("clr_err", 0, 32'(err[0]), 32'h0);
    check("clr_count2", 0, 32'(cnt_of(0)), 32'h0);
    i0 = (i0 + 1) % 4; drive(0, i0); cyc(HOLD);
    check("recover_count", 0, 32'(cnt_of(0)), 32'd1);

    // channel 0 forward, channel 1 reverse, same cycles
    clr_pulse(2'b11);
    i1 = 0;
    for (int k = 0; k < 5; k++) begin
      i0 = (i0 + 1) % 4; i1 = (i1 + 3) % 4;
      drive(0, i0); drive(1, i1);
      cyc(LAT + 1);
      check("step_both", 0, 32'(step), 32'h3);
      cyc(HOLD - LAT - 1);
    end
    check("dual_count", 0, 32'(cnt_of(0)), 32'd5);
    check("dual_count", 1, 32'(cnt_of(1)), 32'hFFFB);
    check("dual_dir", 0, 32'(dir), 32'h1);

    // asynchronous reset with COUNT = 7 and a step in flight
    clr_pulse(2'b11);
    for (int k = 0; k < 7; k++) begin
      i0 = (i0 + 1) % 4; drive(0, i0); cyc(HOLD);
    end
    check("pre_rst_count", 0, 32'(cnt_of(0)), 32'd7);
    i0 = (i0 + 1) % 4; drive(0, i0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", 0, 32'(cnt_of(0)), 32'h0);
    check("arst_flags", 0, 32'({step, err}), 32'h0);
    drive(0, 0); drive(1, 0);
    cyc(3);
    rst = 1'b0;
    pulses0 = 0;
    cyc(10);
    check("post_rst_count", 0, 32'(cnt_of(0)), 32'h0);
    check("post_rst_nostep", 0, pulses0, 32'd0);

    // one-cycle glitch on A
    pulses0 = 0;
    a[0] = 1'b1;
    cyc(1);
    a[0] = 1'b0;
    cyc(HOLD + 4);
    check("glitch_count", 0, 32'(cnt_of(0)), 32'h0);
`ifdef QENC_GLITCH_FILTER_EN
    check("glitch_pulses", 0, pulses0, 32'd0);
`else
    check("glitch_pulses", 0, pulses0, 32'd2);
    check("glitch_dir", 0, 32'(dir[0]), 32'h0);
`endif

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_multi.md
Name: quad_encoder_multi

Overview:
- Parametrised NCH-channel quadrature encoder decoder.
- Per channel: input synchronisation, x4 Gray-transition decoding, signed-direction step pulses, a wrapping position counter and a sticky illegal-transition error.
- Sits between raw encoder pins and the control/display logic.
- Replaces the single-channel fixed encoder FSM, which had no counter, no synchroniser and no error recovery short of reset.

Parameters:
- NCH, 2, number of independent encoder channels (>=1).
- CNT_W, 16, position counter width per channel (>=2).
- SYNC_STAGES, 2, synchroniser flops on each A/B input (>=2).
- FILT_LEN, 4, glitch-filter stability length in cycles (>=2). Used only when QENC_GLITCH_FILTER_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  NCH  encoder phase A per channel (asynchronous to CLK).
- B  input  NCH  encoder phase B per channel (asynchronous to CLK).
- CLR  input  NCH  synchronous per-channel clear of count and error.
- STEP  output  NCH  one-cycle pulse per valid transition.
- DIR  output  NCH  direction of the last valid step: 1 = forward, 0 = reverse.
- COUNT  output  NCH*CNT_W  position counters; channel i occupies bits [i*CNT_W +: CNT_W].
- ERR  output  NCH  sticky illegal-transition flag.

Interface decision: one clock CLK; reset RST is asynchronous and active-high.

Behaviour:
- Reset: all synchroniser flops, filter state, prev and primed bits = 0; STEP=0, DIR=0, COUNT=0, ERR=0. Takes effect immediately on RST rising, even mid-operation.
- Sync: each A[i] and B[i] passes through SYNC_STAGES flops, giving s = {A,B} synchronised.
- Channel state: prev[1:0], primed, err.
- First sample after reset or CLR: load prev = s and set primed=1. No step, no error.
- Forward sequence (A leads): 00→10→11→01→00. Reverse is the opposite order.
- When primed && !err, compare s with prev:
  - s==prev: no action.
  - One-bit change, forward: STEP=1, DIR=1, COUNT+1, prev=s.
  - One-bit change, reverse: STEP=1, DIR=0, COUNT-1, prev=s.
  - Two-bit change (00↔11, 01↔10): ERR=1, prev=s, no STEP, COUNT held.
- While ERR=1: no STEP, COUNT frozen; prev still tracks s.
- COUNT wraps modulo 2^CNT_W in both directions. No saturation.
- STEP is registered and high exactly one cycle per transition.
- DIR holds its value between steps.
- Latency: A/B change captured by the first sync flop at edge k → STEP/COUNT/DIR/ERR update at edge k+SYNC_STAGES.
- CLR[i] sampled at an edge: COUNT=0, ERR=0, STEP=0, primed=0; DIR unchanged. Re-prime occurs on the next cycle.
- CLR coincident with a transition: CLR wins and the transition is not counted.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

Optional Feature:
- Macro: QENC_GLITCH_FILTER_EN.
- Defined:
  - Each channel holds a candidate value and a stability counter of clog2(FILT_LEN) bits.
  - The synchronised value is forwarded to the decoder only after FILT_LEN consecutive equal samples.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Latency increases by FILT_LEN cycles.
  - Filter state resets to 0 and is not affected by CLR.
- Undefined: no filter logic; the synchronised value feeds the decoder directly; FILT_LEN is ignored.

Decomposition:
- Package qenc_pkg:
  - DIR_FWD=1'b1, DIR_REV=1'b0.
  - Gray phase constants PH_00, PH_10, PH_11, PH_01.
  - Function qenc_classify(prev, cur) returning a 2-bit code NONE/FWD/REV/ILLEGAL.
- Sub-module quad_encoder_ch: one channel, containing synchroniser, optional filter, decoder and counter. The top generates NCH instances and packs COUNT.

Test Plan:
- Reset, AB=00 for 8 cycles, then channel 0 forward 10,11,01,00, each held 6 cycles → 4 STEP pulses, DIR=1, COUNT[0]=4, each pulse exactly SYNC_STAGES cycles after its input change.
- From COUNT=0 after CLR, one reverse step 00→01 → COUNT=16'hFFFF, DIR=0. Then a forward step back → COUNT=0.
- Jump 00→11 → ERR=1, no STEP. Then 3 valid forward steps → COUNT unchanged. Then pulse CLR[0] → ERR=0, COUNT=0, next valid step counts +1.
- Channel 0 forward while channel 1 reverse on the same cycles, 5 steps → COUNT[0]=5, COUNT[1]=16'hFFFB, both STEP pulses coincident.
- RST asserted asynchronously mid-sequence with COUNT=7 → COUNT=0, ERR=0, STEP=0 immediately. First sample after release primes without stepping.
- One-cycle glitch on A (00→10→00): with QENC_GLITCH_FILTER_EN → no STEP, COUNT=0. Without the macro → +1 then -1, COUNT=0, two STEP pulses, DIR ends at 0.
